// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencer feeding a FIFO_DEPTH-entry {pc, instr} buffer to decode.
// Latency: word fetched in cycle N is visible to decode at N+1; a full buffer stops requests, redirect flushes.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_count_q, fetch_count_d;
    logic [31:0]      buf_pc_q    [FIFO_DEPTH];
    logic [31:0]      buf_instr_q [FIFO_DEPTH];
    logic             push;
    logic             pop;
    logic             unused_redirect_lsbs;

    // Request depends only on occupancy and redirect, so decode's ready never reaches memory.
    assign imem_req  = ~rst & ~redirect_valid & (count_q != FULL_CNT);
    assign imem_addr = pc_q;
    assign push      = imem_req;
    assign pop       = if_valid & if_ready & ~redirect_valid;

    assign if_valid    = (count_q != '0);
    assign if_pc       = if_valid ? buf_pc_q[rd_ptr_q]    : 32'h0;
    assign if_instr    = if_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
    assign fetch_count = fetch_count_q;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_comb begin
        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d          = pc_q + 32'd4;
                wr_ptr_d      = wr_ptr_q + 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_pc_q[i]    <= 32'h0;
                buf_instr_q[i] <= 32'h0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a queue-based reference.
module tb_instruction_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    logic [31:0] key = 32'h0;
    assign imem_data = imem_addr ^ key;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .fetch_count(fetch_count)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    logic [31:0] mfc;

    int checks = 0;
    int errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RST_PC;
        mfc = 32'h0;
    endtask

    // One clock: apply inputs, compare at negedge, advance the reference at the rising edge.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        logic req;
        rst = r; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
        if (r) model_reset();
        @(negedge clk);
        req = !r && !rv && (mq.size() < DEPTH);
        check("imem_req",    imem_req,    req);
        check("imem_addr",   imem_addr,   mpc);
        check("if_valid",    if_valid,    mq.size() != 0);
        check("if_pc",       if_pc,       mq.size() != 0 ? mq[0].pc : 32'h0);
        check("if_instr",    if_instr,    mq.size() != 0 ? mq[0].instr : 32'h0);
        check("fetch_count", fetch_count, mfc);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (rv) begin
            mq.delete();
            mpc = rp & ~32'h3;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (req) begin
                mq.push_back('{pc: mpc, instr: mpc ^ key});
                mpc = mpc + 32'd4;
                mfc = mfc + 32'd1;
            end
        end
        #1;
    endtask

    logic [31:0] fc_snap;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_if_valid", if_valid,    32'h0);
        check("rst_req",      imem_req,    32'h0);
        check("rst_fcount",   fetch_count, 32'h0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);

        // Stream at full rate with memory word equal to its address.
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);

        // Stall from a fresh reset.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        check("stall_addr", imem_addr, 32'h8);
        check("stall_req",  imem_req,  32'h0);
        check("stall_pc",   if_pc,     32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

        // Redirect with the buffer full.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h40, 0);
        check("redir_n1_valid", if_valid,  32'h0);
        check("redir_n1_addr",  imem_addr, 32'h40);
        cycle(0, 0, 0, 1);
        check("redir_n2_pc",    if_pc,     32'h40);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);

        // Misaligned redirect while decode is ready.
        cycle(0, 1, 32'h43, 1);
        cycle(0, 0, 0, 1);
        check("misalign_pc", if_pc, 32'h40);
        cycle(0, 0, 0, 1);

        // Back-to-back redirects: last wins.
        cycle(0, 1, 32'h100, 1);
        cycle(0, 1, 32'h200, 1);
        cycle(0, 0, 0, 1);
        check("b2b_pc", if_pc, 32'h200);

        // Address wrap.
        fc_snap = fetch_count;
        cycle(0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("wrap_head",   if_pc, 32'hFFFF_FFFC);
        check("wrap_fcount", fetch_count - fc_snap, 32'd2);
        cycle(0, 0, 0, 1);
        check("wrap_next",   if_pc, 32'h0);
        cycle(0, 0, 0, 1);

        // Asynchronous reset mid-cycle with one entry buffered.
        cycle(0, 1, 32'h80, 0);
        cycle(0, 0, 0, 0);
        check("pre_arst_valid", if_valid, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  if_valid,    32'h0);
        check("arst_fcount", fetch_count, 32'h0);
        check("arst_addr",   imem_addr,   RST_PC);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("refetch_pc", if_pc, RST_PC);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, rv, rdy;
            logic [31:0] rp;
            key = $urandom;
            r   = ($urandom_range(0, 49) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            cycle(r, rv, rp, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
